lfsr_burst_gen: RTL and testbench

//  Parametrised successor to the 8-bit ring register: a WIDTH-bit shift-register generator.
//  Two modes: ring rotate, and Fibonacci LFSR with configurable taps.

---
 rtl/lfsr_burst_gen_pkg.sv | 11 +
 rtl/lfsr_burst_gen_if.sv | 23 ++
 rtl/lfsr_burst_gen_next.sv | 17 +
 rtl/lfsr_burst_gen.sv | 51 +++++
 tb/tb_lfsr_burst_gen.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/lfsr_burst_gen_pkg.sv
// lfsr_burst_gen_pkg: shared types and default feedback taps for the burst generator
package lfsr_burst_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} lfsr_state_t;
  typedef enum logic {MODE_RING, MODE_LFSR} lfsr_mode_t;
  localparam logic [31:0] TAPS_8  = 32'h0000_001D;
  localparam logic [31:0] TAPS_16 = 32'h0000_002D;
  localparam logic [31:0] TAPS_32 = 32'h0000_00C5;
  function automatic logic [31:0] default_taps(int w);
    return w == 8 ? TAPS_8 : w == 16 ? TAPS_16 : w == 32 ? TAPS_32 : 32'h3;
  endfunction
endpackage

// File: rtl/lfsr_burst_gen_if.sv
// lfsr_burst_gen_if: control inputs and pattern outputs of the burst generator
interface lfsr_burst_gen_if
  import lfsr_burst_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             syncInt;
  logic             en;
  lfsr_mode_t       mode;
  logic             seed_ld;
  logic [WIDTH-1:0] seed;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] po;
  logic             busy;
  logic             done;
  logic             lockup;
  modport master (output syncInt, en, mode, seed_ld, seed, start, burst_len,
                  input po, busy, done, lockup);
  modport slave  (input syncInt, en, mode, seed_ld, seed, start, burst_len,
                  output po, busy, done, lockup);
endinterface

// File: rtl/lfsr_burst_gen_next.sv
// lfsr_burst_gen_next: next-state function for ring rotate and Fibonacci LFSR
module lfsr_burst_gen_next
  import lfsr_burst_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] po,
  input  lfsr_mode_t       mode,
  output logic [WIDTH-1:0] nxt,
  output logic             zero
);
  always_comb begin
    nxt  = mode == MODE_LFSR ? {^(po & TAPS), po[WIDTH-1:1]} : {po[0], po[WIDTH-1:1]};
    zero = ~|po;
  end
endmodule

// File: rtl/lfsr_burst_gen.sv
// lfsr_burst_gen: ring/LFSR pattern generator with seed load, lock-up recovery and counted bursts
module lfsr_burst_gen
  import lfsr_burst_gen_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter int               CNT_W    = 16,
  parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(1) << (WIDTH - 1)
) (
  input logic               clk,
  input logic               reset,
  lfsr_burst_gen_if.slave   bus
);
  lfsr_state_t      state, state_n;
  logic [WIDTH-1:0] po, po_n, nxt;
  logic [CNT_W-1:0] count, count_n, len, len_n;
  logic             zero, load, begin_burst, step, recover, last;
  lfsr_burst_gen_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next (
    .po(po), .mode(bus.mode), .nxt(nxt), .zero(zero)
  );
  // Loads win over start, and start consumes its cycle without stepping.
  always_comb begin
    load        = bus.syncInt | bus.seed_ld;
    begin_burst = !load && state == IDLE && bus.start;
    step        = !load && bus.en && (state == RUN || (state == IDLE && !bus.start));
    recover     = step && bus.mode == MODE_LFSR && zero;
    last        = step && state == RUN && len != '0 && count + CNT_W'(1) == len;
    state_n     = load ? IDLE : begin_burst ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    po_n        = bus.syncInt ? INIT_VAL : bus.seed_ld ? bus.seed : step ? (recover ? INIT_VAL : nxt) : po;
    count_n     = (load || begin_burst) ? '0 : (step && state == RUN) ? count + CNT_W'(1) : count;
    len_n       = begin_burst ? bus.burst_len : len;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      po         <= '0;
      count      <= '0;
      len        <= '0;
      bus.lockup <= 1'b0;
    end else begin
      state      <= state_n;
      po         <= po_n;
      count      <= count_n;
      len        <= len_n;
      bus.lockup <= recover;
    end
  end
  assign bus.po   = po;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_lfsr_burst_gen.sv
// tb_lfsr_burst_gen: directed checks of ring, LFSR, lock-up recovery, bursts, stalls and aborts
module tb_lfsr_burst_gen;
  import lfsr_burst_gen_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  lfsr_burst_gen_if #(.WIDTH(8), .CNT_W(16)) bus ();
  lfsr_burst_gen dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] ring_exp [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    logic [7:0] lfsr_exp [5] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h87};
    int n;
    logic zero_seen, done_seen;
    reset = 1'b1;
    bus.syncInt = 1'b0; bus.en = 1'b0; bus.mode = MODE_RING; bus.seed_ld = 1'b0;
    bus.seed = 8'h00; bus.start = 1'b0; bus.burst_len = 16'd0;
    tick(); tick();
    chk("reset_po", bus.po, 8'h00);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_lockup", bus.lockup, 0);
    reset = 1'b0;
    bus.syncInt = 1'b1; bus.en = 1'b1;
    tick();
    chk("sync_po", bus.po, 8'h80);
    bus.syncInt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ring_%0d", i), bus.po, ring_exp[i]);
    end
    bus.seed_ld = 1'b1; bus.seed = 8'h01; bus.mode = MODE_LFSR;
    tick();
    chk("seed_po", bus.po, 8'h01);
    bus.seed_ld = 1'b0;
    tick();
    chk("lfsr_a", bus.po, 8'h80);
    tick();
    chk("lfsr_b", bus.po, 8'h40);
    bus.seed_ld = 1'b1; bus.seed = 8'hFF;
    tick();
    bus.seed_ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("lfsr_ff_%0d", i), bus.po, lfsr_exp[i]);
    end
    n = 5;
    zero_seen = 1'b0;
    while (n < 300) begin
      tick();
      n++;
      if (bus.po == 8'h00) zero_seen = 1'b1;
      if (bus.po == 8'hFF) break;
    end
    chk("lfsr_period", n, 255);
    chk("lfsr_no_zero", zero_seen, 0);
    bus.seed_ld = 1'b1; bus.seed = 8'h00;
    tick();
    bus.seed_ld = 1'b0;
    chk("zero_loaded", bus.po, 8'h00);
    chk("zero_no_lockup", bus.lockup, 0);
    tick();
    chk("recover_po", bus.po, 8'h80);
    chk("recover_lockup", bus.lockup, 1);
    tick();
    chk("after_recover_po", bus.po, 8'h40);
    chk("lockup_pulse_end", bus.lockup, 0);
    bus.syncInt = 1'b1; bus.mode = MODE_RING;
    tick();
    bus.syncInt = 1'b0; bus.start = 1'b1; bus.burst_len = 16'd3;
    tick();
    bus.start = 1'b0;
    chk("b3_start_po", bus.po, 8'h80);
    chk("b3_busy0", bus.busy, 1);
    tick();
    chk("b3_po1", bus.po, 8'h40);
    chk("b3_busy1", bus.busy, 1);
    tick();
    chk("b3_po2", bus.po, 8'h20);
    chk("b3_busy2", bus.busy, 1);
    tick();
    chk("b3_po3", bus.po, 8'h10);
    chk("b3_done", bus.done, 1);
    chk("b3_busy_end", bus.busy, 0);
    tick();
    bus.en = 1'b0;
    chk("b3_idle_done", bus.done, 0);
    chk("b3_idle_po", bus.po, 8'h10);
    bus.en = 1'b1; bus.start = 1'b1; bus.burst_len = 16'd5;
    tick();
    bus.start = 1'b0;
    chk("b5_busy", bus.busy, 1);
    tick();
    chk("b5_po1", bus.po, 8'h08);
    tick();
    chk("b5_po2", bus.po, 8'h04);
    bus.en = 1'b0;
    tick();
    chk("b5_stall1_po", bus.po, 8'h04);
    chk("b5_stall1_busy", bus.busy, 1);
    tick();
    chk("b5_stall2_po", bus.po, 8'h04);
    chk("b5_stall2_done", bus.done, 0);
    bus.en = 1'b1;
    tick();
    chk("b5_po3", bus.po, 8'h02);
    tick();
    chk("b5_po4", bus.po, 8'h01);
    chk("b5_not_done", bus.done, 0);
    tick();
    chk("b5_po5", bus.po, 8'h80);
    chk("b5_done", bus.done, 1);
    bus.start = 1'b1; bus.burst_len = 16'd10;
    tick();
    chk("done_ignores_start", bus.busy, 0);
    tick();
    bus.start = 1'b0;
    chk("b10_busy", bus.busy, 1);
    tick();
    tick();
    bus.syncInt = 1'b1;
    tick();
    bus.syncInt = 1'b0;
    chk("abort_po", bus.po, 8'h80);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 0);
    bus.start = 1'b1; bus.burst_len = 16'd10;
    tick();
    bus.start = 1'b0;
    tick();
    chk("rst_burst_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    chk("rst_mid_po", bus.po, 8'h00);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_lockup", bus.lockup, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
